// File: rtl/bit_serial_alu_ctrl.sv
// rtl/bit_serial_alu_ctrl.sv - sequences a WIDTH-bit operation through an external 1-bit ALU slice, LSB first
module bit_serial_alu_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       op_m,
    input  logic [1:0]       op_c,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             s_M1,
    output logic             s_M0,
    output logic             s_C1,
    output logic             s_C0,
    output logic             s_A,
    output logic             s_B,
    output logic             s_Cin,
    input  logic             s_F,
    input  logic             s_Cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_f,
    output logic             rsp_cout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic           last_step;

    assign last_step = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are shifted right each step so the next bit is always at index 1.
    // s_M*/s_C* double as the latched selects for the whole operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            rsp_f    <= '0;
            rsp_cout <= 1'b0;
            s_M1     <= 1'b0;
            s_M0     <= 1'b0;
            s_C1     <= 1'b0;
            s_C0     <= 1'b0;
            s_A      <= 1'b0;
            s_B      <= 1'b0;
            s_Cin    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cnt   <= '0;
                        a_sh  <= a;
                        b_sh  <= b;
                        s_M1  <= op_m[1];
                        s_M0  <= op_m[0];
                        s_C1  <= op_c[1];
                        s_C0  <= op_c[0];
                        s_A   <= a[0];
                        s_B   <= b[0];
                        s_Cin <= cin;
                    end
                end
                RUN: begin
                    rsp_f[cnt] <= s_F;
                    if (last_step) begin
                        rsp_cout <= s_Cout;
                        s_M1     <= 1'b0;
                        s_M0     <= 1'b0;
                        s_C1     <= 1'b0;
                        s_C0     <= 1'b0;
                        s_A      <= 1'b0;
                        s_B      <= 1'b0;
                        s_Cin    <= 1'b0;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        a_sh  <= a_sh >> 1;
                        b_sh  <= b_sh >> 1;
                        s_A   <= a_sh[1];
                        s_B   <= b_sh[1];
                        s_Cin <= s_Cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bit_serial_alu_ctrl.md
Name: bit_serial_alu_ctrl

Overview:
Sequencer that drives an external single-bit ALU slice (ALU_1b-style interface: M1, M0, A, B, Cin, C1, C0 in; F, Cout out) to perform a WIDTH-bit operation one bit per cycle, LSB first. It accepts operands through a valid/ready request, chains each bit's carry-out into the next bit's carry-in, and collects F bits into a WIDTH-bit result. The result is returned through a valid/ready response. It sits between a host/command source and one combinational 1-bit slice, and is the driver end of that slice's interface.

Parameters:
WIDTH, 4, operand/result width in bits; legal range 2..16.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  controller can accept a request
op_m  in  2  mode select {M1,M0}
op_c  in  2  function select {C1,C0}
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in for bit 0
s_M1, s_M0, s_C1, s_C0  out  1 each  slice mode/function select
s_A, s_B, s_Cin  out  1 each  slice operand bits and carry-in
s_F  in  1  slice result bit (combinational from s_*)
s_Cout  in  1  slice carry-out (combinational from s_*)
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_f  out  WIDTH  assembled result, bit i = s_F of step i
rsp_cout  out  1  s_Cout of final step (bit WIDTH-1)

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst_n low at an edge), from any state including mid-RUN/DONE:
  - state becomes IDLE; bit counter = 0.
  - req_ready = 1 after the edge; rsp_valid = 0; rsp_f = 0; rsp_cout = 0.
  - All s_* outputs = 0.
  - An in-flight operation is abandoned and never reported.
- IDLE:
  - req_ready = 1; all s_* = 0.
  - On an edge with req_valid=1, latch a, b, cin, op_m, op_c; counter = 0; go to RUN.
- RUN:
  - req_ready = 0; req_valid is ignored.
  - During step i (i = 0..WIDTH-1):
    - s_A = a_lat[i], s_B = b_lat[i].
    - s_Cin = cin_lat when i=0, else the registered s_Cout of step i-1.
    - {s_M1,s_M0} = op_m_lat, {s_C1,s_C0} = op_c_lat, constant for the whole operation.
  - s_* outputs are registered; they change only at clock edges.
  - At the end of step i, capture s_F into rsp_f[i] and s_Cout into the carry register.
  - After step WIDTH-1, rsp_cout = captured s_Cout; go to DONE.
  - Carry chaining is unconditional, independent of mode.
  - Changes on a, b, cin, op_m, op_c after acceptance have no effect.
- DONE:
  - rsp_valid = 1; rsp_f and rsp_cout are held stable; all s_* = 0; req_ready = 0.
  - On an edge with rsp_ready=1: rsp_valid = 0, go to IDLE. rsp_f and rsp_cout keep their last value until the next operation's first capture.
- Latency: request accepted at edge T → step i occupies cycle T+1+i → rsp_valid first high in cycle T+WIDTH+1.
- Throughput: at most one operation per WIDTH+2 cycles. There is no back-to-back acceptance, because req_ready is low in DONE.
- Bit counter: ceil(log2(WIDTH)) bits; it does not wrap within an operation.

Test Plan:
Bench models the slice as a full adder: F = A^B^Cin, Cout = majority(A,B,Cin). WIDTH=4 throughout.
- Reset: hold rst_n=0 for 2 cycles with req_valid=1 → req_ready=1, rsp_valid=0, rsp_f=0, all s_*=0, no operation starts.
- Add: a=4'b0101, b=4'b0011, cin=0, op_m=2'b11, op_c=2'b00 → per step, s_A=1,0,1,0; s_B=1,1,0,0; s_Cin=0,1,1,1. rsp_valid rises at cycle T+5 with rsp_f=4'b1000, rsp_cout=0.
- Wrap: a=4'hF, b=4'h0, cin=1 → rsp_f=4'h0, rsp_cout=1.
- Backpressure: hold rsp_ready=0 for 3 cycles in DONE while req_valid=1 with new operands → rsp_valid and rsp_f stay stable, req_ready=0, the new request is not accepted. Raise rsp_ready → IDLE next cycle, then the new request is accepted.
- Reset mid-operation: assert rst_n=0 during step 2 → next cycle IDLE, all s_*=0, rsp_valid never asserts for that operation.
- Select passthrough: op_m=2'b10, op_c=2'b01, then toggle op_m/op_c during RUN → s_M1=1, s_M0=0, s_C1=0, s_C0=1 for all 4 steps. All four are 0 in IDLE and DONE.
